dds_burst_ctrl: RTL and testbench
=================================

DDS_BURST_CTRL -- requirements
Module: dds_burst_ctrl

Interface
REQ-001 Parameter ACC_W, default 16, phase accumulator width (minimum 4).
REQ-002 Parameter CNT_W, default 8, burst period counter width.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a burst; sampled only in IDLE.
REQ-006 ftw  input  ACC_W  frequency tuning word; latched on start acceptance.
REQ-007 burst_len  input  CNT_W  number of full waveform periods; 0 means continuous; latched on start acceptance.
REQ-008 stop  input  1  abort request; sampled only in RUN.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 addr  output  3  waveform table address, equal to the top 3 bits of the phase accumulator.
REQ-012 addr_valid  output  1  addr is a live sample; equal to busy.
REQ-013 cycles_done  output  CNT_W  periods completed in current or last burst.

Function
REQ-014 Three states SHALL exist: IDLE, RUN, FIN; all outputs SHALL be registered or decoded from registered state only.
REQ-015 In IDLE, start=1 with ftw!=0 SHALL latch ftw_q/len_q, clear acc and cycles_done to 0, and enter RUN next cycle.
REQ-016 In IDLE, start=1 with ftw==0 SHALL be ignored (no state change, no done).
REQ-017 start in RUN or FIN SHALL be ignored; ftw/burst_len changes after acceptance SHALL have no effect.
REQ-018 The first RUN cycle SHALL present addr=0 with addr_valid=1 (one cycle latency from start sample).
REQ-019 Each RUN cycle SHALL update acc <= (acc + ftw_q) mod 2^ACC_W; wrap = carry out of this add.
REQ-020 On each wrap, cycles_done SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-021 If len_q!=0 and a wrap makes the incremented count equal len_q, next state SHALL be FIN.
REQ-022 If len_q==0, RUN SHALL continue until stop; wraps still counted with saturation.
REQ-023 stop=1 in RUN SHALL force next state FIN; a wrap in the same cycle SHALL still be counted.
REQ-024 On entering FIN, acc SHALL be cleared to 0; busy=addr_valid=0, done=1 for exactly the FIN cycle.
REQ-025 FIN SHALL unconditionally return to IDLE next cycle; start during FIN is not accepted.
REQ-026 cycles_done SHALL hold its final value in IDLE until the next accepted start.
REQ-027 addr SHALL read 0 whenever not in RUN.

Reset
REQ-028 rst=1 SHALL force state IDLE, acc=0, ftw_q=0, len_q=0, cycles_done=0, busy=0, done=0, addr_valid=0, addr=0 at the next edge.
REQ-029 rst takes priority over start, stop and wrap in the same cycle.
REQ-030 rst asserted in RUN or FIN SHALL return to IDLE without producing a done pulse.

Verification
REQ-031 ACC_W=16, ftw=0x2000, burst_len=2, start pulse -> 16 RUN cycles, addr 0,1..7,0,1..7; then done=1 one cycle; cycles_done=2; busy low after.
REQ-032 ftw=0x4000, burst_len=0, stop asserted on RUN cycle 10 -> addr sequence 0,2,4,6 repeating; FIN follows cycle 10; cycles_done=2.
REQ-033 ftw=0x2000, burst_len=1, stop on the 8th RUN cycle (wrap cycle) -> cycles_done=1, single done pulse, no extra RUN cycle.
REQ-034 start with ftw=0 in IDLE -> busy stays 0, done never asserted; start during RUN with new ftw -> addr stepping unchanged.
REQ-035 rst pulsed mid-RUN (cycle 5) -> next cycle all outputs 0, state IDLE, no done; subsequent start runs normally.
REQ-036 CNT_W=2, burst_len=0, ftw=0x8000, run 20 cycles then stop -> cycles_done saturates at 3.

Source files
------------

// File: rtl/dds_burst_ctrl.sv
// Burst controller for a DDS phase accumulator.
// Steps a waveform table address for a counted or open-ended number of periods.
module dds_burst_ctrl #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] ftw,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic [2:0]       addr,
    output logic             addr_valid,
    output logic [CNT_W-1:0] cycles_done
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc, ftw_q;
    logic [CNT_W-1:0] len_q, cnt;
    logic [ACC_W:0]   sum;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic             wrap, hit, accept;

    assign sum     = {1'b0, acc} + {1'b0, ftw_q};
    assign wrap    = sum[ACC_W];
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign cnt_sat = cnt_inc[CNT_W] ? cnt : cnt_inc[CNT_W-1:0];
    // Burst ends on the wrap that brings the count up to the requested length
    assign hit     = wrap && (len_q != '0) && (cnt_inc == {1'b0, len_q});
    assign accept  = start && (ftw != '0);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (stop || hit) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            ftw_q <= '0;
            len_q <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        ftw_q <= ftw;
                        len_q <= burst_len;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= (state_nx == FIN) ? '0 : sum[ACC_W-1:0];
                    if (wrap) cnt <= cnt_sat;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state == RUN);
    assign addr_valid  = busy;
    assign done        = (state == FIN);
    assign addr        = busy ? acc[ACC_W-1 -: 3] : 3'b000;
    assign cycles_done = cnt;

endmodule

// File: tb/tb_dds_burst_ctrl.sv
// Randomized scoreboard bench for dds_burst_ctrl.
// Expected addresses and completion counts come from a period-arithmetic model.
module tb_dds_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [15:0] ftw;
    logic [7:0]  burst_len;
    logic        busy, done, addr_valid;
    logic [2:0]  addr;
    logic [7:0]  cycles_done;

    logic        s_rst, s_start, s_stop;
    logic [15:0] s_ftw;
    logic [1:0]  s_len;
    logic        s_busy, s_done, s_addr_valid;
    logic [2:0]  s_addr;
    logic [1:0]  s_cycles_done;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit is_done;
        int val;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    dds_burst_ctrl #(.ACC_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .ftw(ftw),
        .burst_len(burst_len), .stop(stop), .busy(busy),
        .done(done), .addr(addr), .addr_valid(addr_valid),
        .cycles_done(cycles_done)
    );

    dds_burst_ctrl #(.ACC_W(16), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(s_rst), .start(s_start), .ftw(s_ftw),
        .burst_len(s_len), .stop(s_stop), .busy(s_busy),
        .done(s_done), .addr(s_addr), .addr_valid(s_addr_valid),
        .cycles_done(s_cycles_done)
    );

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Run length and final count from whole periods elapsed: k*ftw/2^16
    function automatic void plan(input int f, input int l, input int s,
                                 input int cmax, output int n, output int c);
        longint w;
        n = 0;
        c = 0;
        for (int k = 1; k <= 10000; k++) begin
            w = (longint'(k) * f) >> 16;
            n = k;
            c = (w > cmax) ? cmax : int'(w);
            if (s == k) break;
            if (l != 0 && w == l) break;
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("addr_valid_eq_busy", addr_valid, busy);
            if (busy) begin
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    chk("unexpected_run_cycle", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("addr", addr, e.val);
                end
            end else begin
                chk("addr_idle_zero", addr, 0);
            end
            if (done) begin
                chk("done_not_busy", busy, 0);
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cycles_done_at_done", cycles_done, e.val);
                end
            end
        end
    end

    task automatic run_burst(input int f, input int l, input int s, input int r);
        int n, c, nrun;
        bit rst_hit;
        plan(f, l, s, 255, n, c);
        rst_hit = (r != 0 && r <= n);
        nrun = rst_hit ? r : n;
        for (int k = 1; k <= nrun; k++)
            exp_q.push_back('{1'b0, (((k - 1) * f) & 32'hFFFF) >> 13});
        if (!rst_hit) exp_q.push_back('{1'b1, c});
        @(negedge clk);
        start = 1'b1;
        ftw = 16'(f);
        burst_len = 8'(l);
        @(negedge clk);
        start = 1'b0;
        ftw = 16'($urandom);
        burst_len = 8'($urandom);
        for (int j = 1; j <= nrun; j++) begin
            stop = (j == s);
            rst = (j == r);
            start = 1'($urandom_range(0, 1));
            ftw = 16'($urandom);
            @(negedge clk);
        end
        stop = 1'b0;
        rst = 1'b0;
        if (rst_hit) begin
            start = 1'b0;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_addr", addr, 0);
            chk("rst_cycles", cycles_done, 0);
        end else begin
            start = 1'b1;
            ftw = 16'h1234;
            @(negedge clk);
            start = 1'b0;
            chk("fin_start_ignored", busy, 0);
            chk("hold_cycles", cycles_done, c);
            @(negedge clk);
            chk("hold_cycles2", cycles_done, c);
        end
    endtask

    initial begin
        int f, l, s, r, n, c;
        rst = 1'b1; start = 1'b0; stop = 1'b0; ftw = '0; burst_len = '0;
        s_rst = 1'b1; s_start = 1'b0; s_stop = 1'b0; s_ftw = '0; s_len = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_addr", addr, 0);
        chk("reset_addr_valid", addr_valid, 0);
        chk("reset_cycles", cycles_done, 0);
        rst = 1'b0;
        s_rst = 1'b0;
        mon_en = 1'b1;

        run_burst(32'h2000, 2, 0, 0);
        run_burst(32'h4000, 0, 10, 0);
        run_burst(32'h2000, 1, 8, 0);

        start = 1'b1;
        ftw = '0;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("ftw0_busy", busy, 0);
        @(negedge clk);
        chk("ftw0_busy2", busy, 0);

        run_burst(32'h2000, 3, 0, 5);
        run_burst(32'h3000, 1, 0, 0);

        for (int i = 0; i < 30; i++) begin
            f = $urandom_range(16'h0800, 16'hFFFF);
            l = $urandom_range(0, 3);
            if (l == 0) s = $urandom_range(1, 40);
            else s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0;
            r = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : 0;
            run_burst(f, l, s, r);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        plan(32'h8000, 0, 20, 3, n, c);
        s_start = 1'b1;
        s_ftw = 16'h8000;
        s_len = 2'd0;
        @(negedge clk);
        s_start = 1'b0;
        for (int j = 1; j <= n; j++) begin
            chk("sat_busy", s_busy, 1);
            s_stop = (j == 20);
            @(negedge clk);
        end
        s_stop = 1'b0;
        chk("sat_done", s_done, 1);
        chk("sat_cycles", s_cycles_done, c);
        @(negedge clk);
        chk("sat_idle", s_busy, 0);
        chk("sat_hold", s_cycles_done, c);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
